// File: rtl/sha256_job_sched_if.sv
// rtl/sha256_job_sched_if.sv - job request and tagged result ports of the SHA-256 job scheduler
interface sha256_job_sched_if #(
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [255:0]     in_state;
    logic [511:0]     in_block;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [255:0]     out_hash;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_state, in_block, in_tag, out_ready,
        input  in_ready, out_valid, out_hash, out_tag
    );

    modport slave (
        input  in_valid, in_state, in_block, in_tag, out_ready,
        output in_ready, out_valid, out_hash, out_tag
    );
endinterface

// File: rtl/sha256_job_sched.sv
// rtl/sha256_job_sched.sv - issue/collect controller for a folded SHA-256 transform pipeline
module sha256_job_sched #(
    parameter int LOOP  = 4,
    parameter int TAG_W = 8,
    parameter int DEPTH = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    sha256_job_sched_if.slave   job,
    output logic                t_feedback,
    output logic [5:0]          t_cnt,
    output logic [255:0]        t_rx_state,
    output logic [511:0]        t_rx_input,
    input  logic [255:0]        t_tx_hash,
    output logic                busy
);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DLY = 65;

    logic [5:0]           cnt;
    logic [255:0]         state_q;
    logic                 state_loaded;
    logic [CW-1:0]        credits;
    logic [DLY-1:0]       dl_v;
    logic [DLY*TAG_W-1:0] dl_tag;
    logic [255:0]         mem_hash [DEPTH];
    logic [TAG_W-1:0]     mem_tag  [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        fill;

    logic same_state;
    logic state_chg;
    logic accept;
    logic pop;
    logic capture;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // All in-flight jobs share state_q because the transform adds rx_state at completion.
    assign same_state   = state_loaded && (job.in_state == state_q);
    assign state_chg    = job.in_valid && !same_state;
    assign job.in_ready = (cnt == 6'd0) && same_state && (credits < CW'(DEPTH));
    assign accept       = job.in_valid && job.in_ready;
    assign pop          = job.out_valid && job.out_ready;
    assign capture      = dl_v[DLY-1];

    assign job.out_valid = (fill != '0);
    assign job.out_hash  = job.out_valid ? mem_hash[rd_ptr] : '0;
    assign job.out_tag   = job.out_valid ? mem_tag[rd_ptr]  : '0;

    assign t_cnt      = cnt;
    assign t_feedback = (cnt != 6'd0);
    assign t_rx_state = state_q;
    assign t_rx_input = job.in_block;
    assign busy       = (credits != '0) || state_chg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt          <= 6'd0;
            state_q      <= '0;
            state_loaded <= 1'b0;
            credits      <= '0;
            dl_v         <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill         <= '0;
        end else begin
            cnt <= (cnt == 6'(LOOP - 1)) ? 6'd0 : cnt + 6'd1;
            // A new chaining state may only be swapped in once nothing is in flight or queued.
            if (state_chg && (credits == '0)) begin
                state_q      <= job.in_state;
                state_loaded <= 1'b1;
            end
            credits <= credits + CW'(accept) - CW'(pop);
            dl_v    <= {dl_v[DLY-2:0], accept};
            if (capture) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            fill <= fill + CW'(capture) - CW'(pop);
        end
    end

    // Credits bound fill to DEPTH, so a capture never lands on an occupied entry.
    always_ff @(posedge clk) begin
        dl_tag <= {dl_tag[(DLY-1)*TAG_W-1:0], job.in_tag};
        if (capture) begin
            mem_hash[wr_ptr] <= t_tx_hash;
            mem_tag[wr_ptr]  <= dl_tag[DLY*TAG_W-1 -: TAG_W];
        end
    end
endmodule

// File: tb/tb_sha256_job_sched.sv
// tb/tb_sha256_job_sched.sv - self-checking bench for sha256_job_sched with a behavioural transform model
module tb_sha256_job_sched;
    localparam int LOOP  = 4;
    localparam int TAG_W = 8;
    localparam int DEPTH = 32;
    localparam int LAT   = 65;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] IV =
        256'h5be0cd19_1f83d9ab_9b05688c_510e527f_a54ff53a_3c6ef372_bb67ae85_6a09e667;
    localparam logic [255:0] ABC_HASH =
        256'hf20015ad_b410ff61_96177a9c_b00361a3_5dae2223_414140de_8f01cfea_ba7816bf;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         t_feedback;
    logic [5:0]   t_cnt;
    logic [255:0] t_rx_state;
    logic [511:0] t_rx_input;
    logic [255:0] t_tx_hash;
    logic         busy;

    always #5 clk = ~clk;

    sha256_job_sched_if #(.TAG_W(TAG_W)) jif ();

    sha256_job_sched #(.LOOP(LOOP), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .job        (jif),
        .t_feedback (t_feedback),
        .t_cnt      (t_cnt),
        .t_rx_state (t_rx_state),
        .t_rx_input (t_rx_input),
        .t_tx_hash  (t_tx_hash),
        .busy       (busy)
    );

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Plain SHA-256 compression plus feed-forward, word 0 in the low bits.
    function automatic logic [255:0] sha_comp(input logic [255:0] st, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) w[i] = blk[32*i +: 32];
        for (int i = 16; i < 64; i++)
            w[i] = (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        for (int i = 0; i < 8; i++) v[i] = st[32*i +: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
            t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[32*i +: 32] = st[32*i +: 32] + v[i];
        return r;
    endfunction

    // Transform stand-in: hashes what is presented on issue slots, result registered 64 edges later.
    logic [64*256-1:0] pipe;
    logic [255:0]      pipe_in;
    always @(posedge clk) begin
        pipe_in = (t_cnt == 6'd0) ? sha_comp(t_rx_state, t_rx_input) : {8{$urandom}};
        t_tx_hash <= pipe[64*256-1 -: 256];
        pipe      <= {pipe[63*256-1:0], pipe_in};
    end

    typedef struct {
        logic [255:0]     hash;
        logic [TAG_W-1:0] tag;
    } res_t;

    typedef struct {
        logic [255:0]     st;
        logic [511:0]     blk;
        logic [TAG_W-1:0] tag;
        logic [255:0]     exp_hash;
    } vec_t;

    res_t q[$];
    int   n_cmp, n_fail, cyc, n_acc, n_pop, last_acc, last_pop, tagc;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: runs at the falling edge and predicts the handshakes of the next rising edge.
    task automatic mon();
        res_t e;
        if (!reset_n) begin
            q.delete();
            return;
        end
        if (jif.out_valid && q.size() == 0) check("spurious_out_valid", jif.out_valid, 1'b0);
        if (jif.out_valid && jif.out_ready && q.size() != 0) begin
            e = q.pop_front();
            check("sb_hash", jif.out_hash, e.hash);
            check("sb_tag", jif.out_tag, e.tag);
            n_pop++;
            last_pop = cyc + 1;
        end
        if (jif.in_valid && jif.in_ready) begin
            e.hash = sha_comp(jif.in_state, jif.in_block);
            e.tag  = jif.in_tag;
            q.push_back(e);
            n_acc++;
            last_acc = cyc + 1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic send_job(input logic [255:0] st, input logic [511:0] blk, input logic [TAG_W-1:0] tag);
        int a0;
        a0 = n_acc;
        jif.in_valid = 1'b1;
        jif.in_state = st;
        jif.in_block = blk;
        jif.in_tag   = tag;
        for (int i = 0; i < 300 && n_acc == a0; i++) tick();
        jif.in_valid = 1'b0;
        check("job_accepted", n_acc != a0, 1'b1);
    endtask

    task automatic wait_out(input string nm);
        for (int i = 0; i < 150 && !jif.out_valid; i++) tick();
        check(nm, jif.out_valid, 1'b1);
    endtask

    task automatic drain(input string nm);
        jif.out_ready = 1'b1;
        for (int i = 0; i < 400 && q.size() != 0; i++) tick();
        tick();
        check(nm, q.size(), 0);
        check({nm, "_out_valid"}, jif.out_valid, 1'b0);
    endtask

    task automatic rst_chk(input string pfx);
        check({pfx, "_out_valid"}, jif.out_valid, 1'b0);
        check({pfx, "_in_ready"}, jif.in_ready, 1'b0);
        check({pfx, "_busy"}, busy, 1'b0);
        check({pfx, "_out_hash"}, jif.out_hash, '0);
        check({pfx, "_out_tag"}, jif.out_tag, '0);
        check({pfx, "_t_feedback"}, t_feedback, 1'b0);
        check({pfx, "_t_cnt"}, t_cnt, '0);
        check({pfx, "_t_rx_state"}, t_rx_state, '0);
    endtask

    initial begin
        vec_t         tbl [4];
        logic [511:0] abc;
        logic [255:0] sa, sb;
        int           a0, p0, first_acc, seen, st_sel;

        n_cmp = 0; n_fail = 0; cyc = 0; n_acc = 0; n_pop = 0; last_acc = 0; last_pop = 0; tagc = 0;
        reset_n = 1'b0;
        jif.in_valid = 1'b0; jif.in_state = '0; jif.in_block = '0; jif.in_tag = '0; jif.out_ready = 1'b0;

        abc = '0;
        abc[31:0]    = 32'h61626380;
        abc[511:480] = 32'h00000018;
        tbl[0] = '{IV, abc, 8'h5A, ABC_HASH};
        for (int i = 1; i < 4; i++) begin
            tbl[i].st       = (i == 3) ? rnd256() : IV;
            tbl[i].blk      = rnd512();
            tbl[i].tag      = TAG_W'(8'hA0 + i);
            tbl[i].exp_hash = sha_comp(tbl[i].st, tbl[i].blk);
        end

        repeat (3) tick();
        rst_chk("reset");
        reset_n = 1'b1;
        tick();

        // Single jobs one at a time, including the "abc" known answer and a state change.
        jif.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_job(tbl[i].st, tbl[i].blk, tbl[i].tag);
            wait_out("tbl_out_valid");
            check("tbl_latency", cyc - last_acc, LAT);
            check("tbl_hash", jif.out_hash, tbl[i].exp_hash);
            check("tbl_tag", jif.out_tag, tbl[i].tag);
        end
        drain("tbl_drain");

        // Streaming at full issue rate.
        first_acc = 0;
        for (int i = 0; i < 40; i++) begin
            send_job(IV, rnd512(), TAG_W'(i));
            if (i == 0) first_acc = last_acc;
        end
        check("stream_span", last_acc - first_acc, 39 * LOOP);
        drain("stream_drain");

        // Back-pressure: credits stop acceptance at DEPTH.
        jif.out_ready = 1'b0;
        a0 = n_acc;
        jif.in_valid = 1'b1; jif.in_state = IV; jif.in_block = rnd512(); jif.in_tag = TAG_W'(tagc++);
        for (int i = 0; i < 300; i++) begin
            p0 = n_acc;
            tick();
            if (n_acc != p0) begin jif.in_block = rnd512(); jif.in_tag = TAG_W'(tagc++); end
        end
        seen = 0;
        for (int i = 0; i < 2 * LOOP; i++) begin tick(); if (jif.in_ready) seen++; end
        check("bp_accepts", n_acc - a0, DEPTH);
        check("bp_in_ready_low", seen, 0);
        jif.in_valid = 1'b0;
        p0 = n_pop;
        drain("bp_drain");
        check("bp_pops", n_pop - p0, DEPTH);
        seen = 0;
        for (int i = 0; i < LOOP + 1; i++) begin if (jif.in_ready) seen++; tick(); end
        check("bp_in_ready_resumes", seen != 0, 1'b1);

        // State change is held until the last job on the old state has been popped.
        sa = rnd256(); sb = rnd256();
        jif.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_job(sa, rnd512(), TAG_W'(tagc++));
        jif.in_valid = 1'b1; jif.in_state = sb; jif.in_block = rnd512(); jif.in_tag = TAG_W'(tagc++);
        a0 = n_acc; p0 = n_pop; seen = 0;
        for (int i = 0; i < 80; i++) begin tick(); if (jif.in_ready) seen++; end
        check("sc_held", seen, 0);
        check("sc_busy", busy, 1'b1);
        jif.out_ready = 1'b1;
        for (int i = 0; i < 100 && n_acc == a0; i++) tick();
        jif.in_valid = 1'b0;
        check("sc_accepted", n_acc - a0, 1);
        check("sc_pops_first", n_pop - p0, 3);
        check("sc_load_gap", (last_acc - last_pop >= 2) && (last_acc - last_pop <= LOOP + 1), 1'b1);
        check("sc_rx_state", t_rx_state, sb);
        drain("sc_drain");

        // Accept and pop on the same edge at DEPTH-1 credits.
        jif.out_ready = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) send_job(IV, rnd512(), TAG_W'(tagc++));
        for (int i = 0; i < 150 && !(jif.out_valid && jif.in_ready); i++) tick();
        a0 = n_acc; p0 = n_pop;
        jif.in_valid = 1'b1; jif.in_block = rnd512(); jif.in_tag = TAG_W'(tagc++); jif.out_ready = 1'b1;
        tick();
        jif.in_valid = 1'b0; jif.out_ready = 1'b0;
        check("sim_accept", n_acc - a0, 1);
        check("sim_pop", n_pop - p0, 1);
        a0 = n_acc;
        jif.in_valid = 1'b1; jif.in_block = rnd512(); jif.in_tag = TAG_W'(tagc++);
        for (int i = 0; i < 3 * LOOP; i++) begin
            p0 = n_acc;
            tick();
            if (n_acc != p0) begin jif.in_block = rnd512(); jif.in_tag = TAG_W'(tagc++); end
        end
        jif.in_valid = 1'b0;
        check("sim_one_more", n_acc - a0, 1);
        drain("sim_drain");

        // Reset while jobs are in flight.
        for (int i = 0; i < 5; i++) send_job(IV, rnd512(), TAG_W'(tagc++));
        repeat (30) tick();
        reset_n = 1'b0;
        #1;
        rst_chk("midrst");
        repeat (3) tick();
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 120; i++) begin tick(); if (jif.out_valid) seen++; end
        check("midrst_no_stale", seen, 0);
        send_job(IV, abc, 8'h3C);
        wait_out("midrst_out_valid");
        check("midrst_latency", cyc - last_acc, LAT);
        check("midrst_hash", jif.out_hash, ABC_HASH);
        drain("midrst_drain");

        // Random traffic with occasional state switches and random back-pressure.
        sa = rnd256(); sb = rnd256(); st_sel = 0;
        for (int i = 0; i < 1500; i++) begin
            if (!jif.in_valid && $urandom_range(9) < 7) begin
                if ($urandom_range(24) == 0) st_sel = 1 - st_sel;
                jif.in_valid = 1'b1;
                jif.in_state = (st_sel != 0) ? sb : sa;
                jif.in_block = rnd512();
                jif.in_tag   = TAG_W'(tagc++);
            end
            jif.out_ready = ($urandom_range(9) < 6);
            a0 = n_acc;
            tick();
            if (n_acc != a0) jif.in_valid = 1'b0;
        end
        jif.in_valid = 1'b0;
        drain("rand_drain");
        check("final_busy", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/sha256_job_sched.md
# sha256_job_sched

Issue/collect controller on the far side of the SHA-256 transform pipeline. It accepts hash jobs (chaining state, 512-bit block, tag) on a valid/ready port and drives the transform's `feedback`/`cnt`/`rx_state`/`rx_input` inputs in lock-step with the pipeline's LOOP schedule. It captures `tx_hash` at the exact completion cycle and returns tagged results through a back-pressurable result FIFO. The miner core uses it to stream nonce blocks through one transform instance at full issue rate.

## Interface
- LOOP, 4: transform fold factor; one of 1, 2, 4, 8, 16, 32; must match the transform instance.
- TAG_W, 8: width of the job tag carried alongside each job.
- DEPTH, 32: result FIFO entries and total credit limit. Must be ≥ 1. Full issue rate requires ≥ 65/LOOP + 2.
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  job offered.
- in_ready  out  1  job accepted on an edge where in_valid && in_ready.
- in_state  in  256  chaining state, transform word packing (word 0 in [31:0]).
- in_block  in  512  message block, transform word packing.
- in_tag  in  TAG_W  opaque job tag.
- out_valid  out  1  result available (FIFO head).
- out_ready  in  1  result consumed on an edge where out_valid && out_ready.
- out_hash  out  256  final hash (state + compression), transform packing.
- out_tag  out  TAG_W  tag of the job that produced out_hash.
- t_feedback  out  1  to transform `feedback`.
- t_cnt  out  6  to transform `cnt`.
- t_rx_state  out  256  to transform `rx_state`.
- t_rx_input  out  512  to transform `rx_input`.
- t_tx_hash  in  256  from transform `tx_hash`.
- busy  out  1  credits_used != 0 or state load pending.

## Operation
- Phase counter `cnt`: free-running 0..LOOP-1, wraps to 0; t_cnt = cnt. For LOOP=1 it is constant 0.
- t_feedback = (cnt != 0). t_rx_input = in_block (combinational). t_rx_state = state_q.
- Shared state: every in-flight job uses state_q, because the transform adds rx_state at completion.
  - state_q and state_loaded reset to 0.
  - A job whose in_state != state_q, or any job while !state_loaded, is a state change.
  - A state change waits until credits_used == 0.
  - It then loads state_q <= in_state and sets state_loaded = 1, with in_ready low that cycle.
  - The job is accepted at a later issue slot.
- in_ready = (cnt == 0) && state_loaded && (in_state == state_q) && (credits_used < DEPTH).
- Accept: credits_used += 1. A delay line carries {valid, tag} 65 cycles.
- Capture: when the delay-line output is valid, write {t_tx_hash, tag} into the FIFO.
- FIFO: first-word-fall-through; out_valid = !empty; out_hash/out_tag show the head entry. Pop on out_valid && out_ready, which does credits_used -= 1.
- Accept and pop on the same edge leave credits_used unchanged.
- Credits cover in-flight plus queued jobs, so the FIFO can never overflow and the pipeline never stalls. An unaccepted issue slot injects a bubble that is never captured.
- Ordering: results leave in accept order.

## Timing
- Reset (async assert, sync-safe release): cnt=0, credits_used=0, delay line cleared, FIFO empty.
- Output reset values: out_valid=0, in_ready=0, busy=0, out_hash=0, out_tag=0, t_feedback=0, t_cnt=0, t_rx_state=0.
- Reset mid-operation drops all in-flight and queued jobs. No result from before reset ever appears.
- Job accepted on edge E (cnt==0 during the preceding cycle):
  - transform registers t_tx_hash on edge E+64;
  - controller writes the FIFO on edge E+65;
  - out_valid rises after E+65 if the FIFO was empty.
- Latency: 65 cycles from accept to out_valid.
- Issue rate: at most one job per LOOP cycles.
- Credit-limited case: with out_ready held low, exactly DEPTH jobs are accepted, then in_ready stays 0.
- State-change cost: drain (last pop) + 1 load cycle + wait for the next cnt==0 slot.

## Test plan
- Single job: IV, single-block "abc" padded block, tag 8'h5A → after 65 cycles out_valid=1, out_tag=8'h5A, out_hash = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad (H0 in [31:0]).
- Streaming: 40 jobs with the same state, out_ready=1, LOOP=4 → one accept every 4 cycles, 40 results in order, tags 0..39, each hash matching the software model.
- Back-pressure: out_ready=0, DEPTH=32 → exactly 32 accepts, in_ready then 0. Release out_ready → 32 ordered results, after which in_ready resumes.
- State change: 3 jobs with state A, then a job with state B → B held until the third A result is popped, one load cycle, then B accepted. All four hashes are correct.
- Simultaneous accept+pop at credits_used = DEPTH-1 → credits unchanged and no lost result.
- Reset asserted 30 cycles after 5 accepts → all outputs at reset values, no stale result after release, first new job completes 65 cycles after its accept.
